// File: rtl/tx_send_module_if.sv
// Request and switch-write signal bundle for one tx_send_module instance.
// master drives requests and observes the packet beats; slave is the packet generator.
interface tx_send_module_if #(
    parameter int unsigned PORT_NUB_TOTAL  = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DATA_LENGTH_MAX = 512,
    parameter int unsigned PRIORITY        = 8
);
    localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
    localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
    localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY);

    logic                      start;
    logic                      ready;
    logic                      done;
    logic [WIDTH_SEL-1:0]      dest;
    // 'priority' is a reserved word, so the priority input is carried as prio
    logic [WIDTH_PRIORITY-1:0] prio;
    logic [WIDTH_LENGTH-1:0]   length;
    logic                      wr_sop;
    logic                      wr_eop;
    logic                      wr_vld;
    logic [DATA_WIDTH-1:0]     wr_data;

    modport master (
        output start, dest, prio, length,
        input  ready, done, wr_sop, wr_eop, wr_vld, wr_data
    );

    modport slave (
        input  start, dest, prio, length,
        output ready, done, wr_sop, wr_eop, wr_vld, wr_data
    );
endinterface

// File: rtl/tx_send_module.sv
// Per-port packet generator: one header beat plus 'length' payload beats per accepted start.
// Define SEND_RANDOM_PAYLOAD_EN to replace the counter payload with a Galois LFSR sequence.
module tx_send_module #(
    parameter int unsigned tx_port         = 0,
    parameter int unsigned PORT_NUB_TOTAL  = 16,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned DATA_LENGTH_MAX = 512,
    parameter int unsigned PRIORITY        = 8
) (
    input logic             clk,
    input logic             rst_n,
    tx_send_module_if.slave bus
);
    localparam int unsigned WIDTH_SEL      = $clog2(PORT_NUB_TOTAL);
    localparam int unsigned WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX);
    localparam int unsigned WIDTH_PRIORITY = $clog2(PRIORITY);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HEAD,
        S_DATA,
        S_DONE
    } state_t;

    state_t                    state_q, state_n;
    logic [WIDTH_SEL-1:0]      dest_q, dest_n;
    logic [WIDTH_PRIORITY-1:0] prio_q, prio_n;
    logic [WIDTH_LENGTH-1:0]   len_q, len_n;
    logic [WIDTH_LENGTH-1:0]   cnt_q, cnt_n;
    logic                      ready_q, ready_n;
    logic                      done_q, done_n;
    logic                      sop_q, sop_n;
    logic                      eop_q, eop_n;
    logic                      vld_q, vld_n;
    logic [DATA_WIDTH-1:0]     data_q, data_n;

    logic [WIDTH_LENGTH-1:0]   idx_n;
    logic [WIDTH_LENGTH-1:0]   last_idx;
    logic [DATA_WIDTH-1:0]     pay_word;
    logic [DATA_WIDTH-1:0]     head_word;

    // Index of the payload beat that would be emitted next cycle
    assign idx_n    = (state_q == S_HEAD) ? '0 : cnt_q + WIDTH_LENGTH'(1);
    assign last_idx = len_q - WIDTH_LENGTH'(1);

    assign head_word = DATA_WIDTH'({16'(tx_port), 9'(bus.length), 3'(bus.prio), 4'(bus.dest)});

`ifdef SEND_RANDOM_PAYLOAD_EN
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = {16'hA5A5, 16'(tx_port)};

    logic [31:0] lfsr_q, lfsr_n;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

    assign pay_word = DATA_WIDTH'(lfsr_q);
`else
    assign pay_word = DATA_WIDTH'({8'(tx_port), 4'h0, 4'(dest_q), 16'(idx_n)});
`endif

    // Next-state and next-output logic; outputs are registered one stage below
    always_comb begin
        state_n = state_q;
        dest_n  = dest_q;
        prio_n  = prio_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        ready_n = 1'b0;
        done_n  = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        vld_n   = 1'b0;
        data_n  = '0;
`ifdef SEND_RANDOM_PAYLOAD_EN
        lfsr_n  = lfsr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_n = S_HEAD;
                    dest_n  = bus.dest;
                    prio_n  = bus.prio;
                    len_n   = bus.length;
                    cnt_n   = '0;
                    sop_n   = 1'b1;
                    vld_n   = 1'b1;
                    eop_n   = (bus.length == '0);
                    data_n  = head_word;
`ifdef SEND_RANDOM_PAYLOAD_EN
                    lfsr_n  = LFSR_SEED;
`endif
                end else begin
                    state_n = S_IDLE;
                    ready_n = 1'b1;
                end
            end
            S_HEAD, S_DATA: begin
                if ((state_q == S_HEAD && len_q == '0) ||
                    (state_q == S_DATA && cnt_q == last_idx)) begin
                    state_n = S_DONE;
                    ready_n = 1'b1;
                    done_n  = 1'b1;
                end else begin
                    state_n = S_DATA;
                    cnt_n   = idx_n;
                    vld_n   = 1'b1;
                    eop_n   = (idx_n == last_idx);
                    data_n  = pay_word;
`ifdef SEND_RANDOM_PAYLOAD_EN
                    lfsr_n  = lfsr_step(lfsr_q);
`endif
                end
            end
            default: begin
                state_n = S_IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dest_q  <= '0;
            prio_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            vld_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_n;
            dest_q  <= dest_n;
            prio_q  <= prio_n;
            len_q   <= len_n;
            cnt_q   <= cnt_n;
            ready_q <= ready_n;
            done_q  <= done_n;
            sop_q   <= sop_n;
            eop_q   <= eop_n;
            vld_q   <= vld_n;
            data_q  <= data_n;
        end
    end

`ifdef SEND_RANDOM_PAYLOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_n;
        end
    end
`endif

    assign bus.ready   = ready_q;
    assign bus.done    = done_q;
    assign bus.wr_sop  = sop_q;
    assign bus.wr_eop  = eop_q;
    assign bus.wr_vld  = vld_q;
    assign bus.wr_data = data_q;

endmodule

// File: tb/tb_tx_send_module.sv
// Self-checking bench for tx_send_module: directed scenarios plus random packets
// compared beat by beat against a packet-level reference model.
module tb_tx_send_module;
    localparam int unsigned TX_PORT = 3;
    localparam int unsigned DW      = 32;

    typedef logic [DW+4:0] vec_t;  // {ready, done, sop, eop, vld, data}

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    tx_send_module_if #(
        .PORT_NUB_TOTAL (16),
        .DATA_WIDTH     (DW),
        .DATA_LENGTH_MAX(512),
        .PRIORITY       (8)
    ) bus ();

    tx_send_module #(
        .tx_port        (TX_PORT),
        .PORT_NUB_TOTAL (16),
        .DATA_WIDTH     (DW),
        .DATA_LENGTH_MAX(512),
        .PRIORITY       (8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: header and payload words from the field definitions
    function automatic logic [31:0] model_header(input int d, input int p, input int l);
        longint w;
        w = longint'(TX_PORT) * 65536 + longint'(l) * 128 + longint'(p) * 16 + longint'(d);
        return 32'(w);
    endfunction

    function automatic logic [31:0] model_payload(input int d, input int k);
`ifdef SEND_RANDOM_PAYLOAD_EN
        logic [31:0] s;
        s = 32'hA5A5_0000 + 32'(TX_PORT % 65536);
        for (int i = 0; i < k; i++) begin
            if (s[0]) s = (s >> 1) ^ 32'h8020_0003;
            else      s = s >> 1;
        end
        return s;
`else
        longint w;
        w = longint'(TX_PORT % 256) * 16777216 + longint'(d) * 65536 + longint'(k);
        return 32'(w);
`endif
    endfunction

    function automatic vec_t v_idle();
        return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0};
    endfunction

    function automatic vec_t v_done();
        return {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    endfunction

    function automatic vec_t v_head(input int d, input int p, input int l);
        return {1'b0, 1'b0, 1'b1, (l == 0), 1'b1, model_header(d, p, l)};
    endfunction

    function automatic vec_t v_data(input int d, input int l, input int k);
        return {1'b0, 1'b0, 1'b0, (k == l - 1), 1'b1, model_payload(d, k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input vec_t exp);
        vec_t o;
        o = {bus.ready, bus.done, bus.wr_sop, bus.wr_eop, bus.wr_vld, bus.wr_data};
        total++;
        assert (o === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, exp);
        end
    endtask

    // Reset mid-packet: outputs must drop before the next clock edge
    task automatic do_abort();
        #3;
        rst_n = 1'b0;
        #1;
        check_vec("abort_async", v_idle());
        for (int i = 0; i < 3; i++) begin
            tick();
            check_vec("abort_hold", v_idle());
        end
        #4;
        rst_n = 1'b1;
        tick();
        check_vec("abort_release", v_idle());
    endtask

    // Issue one request now and check every cycle through its done pulse
    task automatic send_pkt(input int d, input int p, input int l,
                            input int poke_at, input int abort_at);
        total++;
        assert (bus.ready === 1'b1) else begin
            bad++;
            $error("FAIL ready_before_start observed=%b expected=1", bus.ready);
        end
        bus.start  = 1'b1;
        bus.dest   = 4'(d);
        bus.prio   = 3'(p);
        bus.length = 9'(l);
        tick();
        bus.start  = 1'b0;
        bus.dest   = 4'($urandom);
        bus.prio   = 3'($urandom);
        bus.length = 9'($urandom);
        check_vec("header", v_head(d, p, l));
        for (int k = 0; k < l; k++) begin
            if (k == abort_at) begin
                do_abort();
                return;
            end
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.dest  = 4'd1;
            end
            tick();
            bus.start = 1'b0;
            check_vec("payload", v_data(d, l, k));
        end
        tick();
        check_vec("done", v_done());
    endtask

    initial begin
        int d, p, l;
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.dest   = '0;
        bus.prio   = '0;
        bus.length = '0;

        repeat (10) @(posedge clk);
        #1;
        check_vec("reset_held", v_idle());
        #4;
        rst_n = 1'b1;
        tick();
        check_vec("reset_release", v_idle());

        // Basic packet, immediately followed back-to-back by a length-31 packet
        send_pkt(5, 2, 15, -1, -1);
        send_pkt(9, 7, 31, -1, -1);
        tick();
        check_vec("idle_after_b2b", v_idle());

        // Zero-length packet
        send_pkt(12, 1, 0, -1, -1);
        tick();
        check_vec("idle_after_zero", v_idle());

        // Start while busy is ignored; nothing follows the packet
        send_pkt(3, 4, 255, 100, -1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_vec("idle_after_busy", v_idle());
        end

        // Abort mid-payload, then a fresh packet
        send_pkt(6, 5, 100, -1, 40);
        send_pkt(2, 3, 7, -1, -1);
        tick();
        check_vec("idle_after_abort", v_idle());

        // Random packets, randomly chained back-to-back
        for (int n = 0; n < 25; n++) begin
            d = int'($urandom_range(0, 15));
            p = int'($urandom_range(0, 7));
            l = int'($urandom_range(0, 40));
            send_pkt(d, p, l, -1, -1);
            if ($urandom_range(0, 1) == 0) begin
                tick();
                check_vec("idle_random", v_idle());
            end
        end
        send_pkt(15, 7, 511, -1, -1);
        tick();
        check_vec("idle_final", v_idle());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
